// File: rtl/uart_reg_pkg.sv
// Shared types and constants for the UART byte-stream register bridge.
package uart_reg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_SEND = 2'd2
    } state_t;

    localparam int         CMD_WR_BIT = 7;
    localparam int         ADDR_W     = 7;
    localparam logic [7:0] FILL_BYTE  = 8'h55;

endpackage

// File: rtl/uart_reg_bank.sv
// Register storage with atomic commit, write strobes and the read-side source mux.
// Read-only registers ignore commits and read from the live status inputs.
module uart_reg_bank
    import uart_reg_pkg::*;
#(
    parameter int                              NUM_REGS  = 16,
    parameter int                              REG_BYTES = 4,
    parameter logic [NUM_REGS-1:0]             RO_MASK   = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS*REG_BYTES*8-1:0] RST_VAL   = {(NUM_REGS*REG_BYTES*8){1'b0}}
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              commit_en,
    input  logic [ADDR_W-1:0]                 commit_addr,
    input  logic [REG_BYTES*8-1:0]            commit_data,
    input  logic [ADDR_W-1:0]                 rd_addr,
    output logic [REG_BYTES*8-1:0]            rd_data,
    input  logic [NUM_REGS*REG_BYTES*8-1:0]   ro_d,
    output logic [NUM_REGS*REG_BYTES*8-1:0]   reg_q,
    output logic [NUM_REGS-1:0]               wr_stb
);

    localparam int W = REG_BYTES * 8;

    // Commit a full register value and pulse its strobe; out-of-range addresses match no slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q  <= RST_VAL;
            wr_stb <= {NUM_REGS{1'b0}};
        end else begin
            wr_stb <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_en && (commit_addr == ADDR_W'(i)) && !RO_MASK[i]) begin
                    reg_q[i*W +: W] <= commit_data;
                    wr_stb[i]       <= 1'b1;
                end else begin
                    wr_stb[i] <= 1'b0;
                end
            end
        end
    end

    // Select the read source: live status for read-only slots, storage otherwise, fill when unmapped.
    always_comb begin
        rd_data = {REG_BYTES{FILL_BYTE}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data = (rd_addr == ADDR_W'(i)) ? (RO_MASK[i] ? ro_d[i*W +: W] : reg_q[i*W +: W])
                                               : rd_data;
        end
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-stream command decoder: [cmd][data LSB..MSB] writes, [cmd] reads with a
// snapshotted multi-byte response under tx backpressure.
module uart_reg_bridge
    import uart_reg_pkg::*;
#(
    parameter int                              NUM_REGS  = 16,
    parameter int                              REG_BYTES = 4,
    parameter logic [NUM_REGS-1:0]             RO_MASK   = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS*REG_BYTES*8-1:0] RST_VAL   = {(NUM_REGS*REG_BYTES*8){1'b0}},
    parameter int                              TIMEOUT   = 960000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic [7:0]                        tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic [NUM_REGS*REG_BYTES*8-1:0]   reg_q,
    input  logic [NUM_REGS*REG_BYTES*8-1:0]   ro_d,
    output logic [NUM_REGS-1:0]               wr_stb,
    output logic [NUM_REGS-1:0]               rd_stb,
    output logic                              timeout_err,
    output logic                              rx_drop,
    output logic                              busy
);

    localparam int              W         = REG_BYTES * 8;
    localparam int              TMO_W     = $clog2(TIMEOUT);
    localparam logic [1:0]      LAST_BYTE = 2'(REG_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        byte_cnt_r;
    logic [W-1:0]      shadow_r;
    logic [W-1:0]      snap_r;
    logic [TMO_W-1:0]  tmo_cnt_r;

    logic [ADDR_W-1:0] cmd_addr_s;
    logic [W-1:0]      rd_data_s;
    logic [W-1:0]      commit_data_s;
    logic [W-1:0]      snap_next_s;
    logic              commit_en_s;

    assign cmd_addr_s = rx_data[ADDR_W-1:0];
    assign busy       = (state_r != IDLE);

    // Merge the final byte into the shadow so the commit lands on the same edge as that byte.
    always_comb begin
        commit_data_s                           = shadow_r;
        commit_data_s[{byte_cnt_r, 3'b000} +: 8] = rx_data;
        commit_en_s = (state_r == WR_DATA) && rx_valid && (byte_cnt_r == LAST_BYTE);
        snap_next_s = snap_r >> 8;
    end

    uart_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .REG_BYTES(REG_BYTES),
        .RO_MASK  (RO_MASK),
        .RST_VAL  (RST_VAL)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .commit_en  (commit_en_s),
        .commit_addr(addr_r),
        .commit_data(commit_data_s),
        .rd_addr    (cmd_addr_s),
        .rd_data    (rd_data_s),
        .ro_d       (ro_d),
        .reg_q      (reg_q),
        .wr_stb     (wr_stb)
    );

    // Command FSM with byte counting, inter-byte timeout and snapshot transmit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            byte_cnt_r  <= 2'd0;
            shadow_r    <= {W{1'b0}};
            snap_r      <= {W{1'b0}};
            tmo_cnt_r   <= {TMO_W{1'b0}};
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            rd_stb      <= {NUM_REGS{1'b0}};
            timeout_err <= 1'b0;
            rx_drop     <= 1'b0;
        end else begin
            rd_stb      <= {NUM_REGS{1'b0}};
            timeout_err <= 1'b0;
            rx_drop     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_valid) begin
                        addr_r     <= cmd_addr_s;
                        byte_cnt_r <= 2'd0;
                        tmo_cnt_r  <= {TMO_W{1'b0}};
                        if (rx_data[CMD_WR_BIT]) begin
                            state_r  <= WR_DATA;
                            shadow_r <= {W{1'b0}};
                        end else begin
                            state_r  <= RD_SEND;
                            snap_r   <= rd_data_s;
                            tx_data  <= rd_data_s[7:0];
                            tx_valid <= 1'b1;
                            for (int i = 0; i < NUM_REGS; i++) begin
                                rd_stb[i] <= (cmd_addr_s == ADDR_W'(i));
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        tmo_cnt_r <= {TMO_W{1'b0}};
                        if (byte_cnt_r == LAST_BYTE) begin
                            state_r  <= IDLE;
                            shadow_r <= {W{1'b0}};
                        end else begin
                            shadow_r[{byte_cnt_r, 3'b000} +: 8] <= rx_data;
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state_r     <= IDLE;
                        shadow_r    <= {W{1'b0}};
                        tmo_cnt_r   <= {TMO_W{1'b0}};
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                RD_SEND: begin
                    rx_drop <= rx_valid;
                    if (tx_valid && tx_ready) begin
                        if (byte_cnt_r == LAST_BYTE) begin
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            state_r  <= IDLE;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            snap_r     <= snap_next_s;
                            tx_data    <= snap_next_s[7:0];
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed self-checking bench for uart_reg_bridge (16 x 32-bit registers, reg 6 read-only).
module tb_uart_reg_bridge;

    localparam int NR  = 16;
    localparam int TMO = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [511:0]  reg_q;
    logic [511:0]  ro_d;
    logic [NR-1:0] wr_stb;
    logic [NR-1:0] rd_stb;
    logic          timeout_err;
    logic          rx_drop;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_pulses = 0, rd_pulses = 0, tmo_pulses = 0, drop_pulses = 0, accepts = 0;
    logic [NR-1:0] last_wr = 16'h0000;
    logic [NR-1:0] last_rd = 16'h0000;
    logic [31:0]   model [NR];

    always #5 clk = ~clk;

    uart_reg_bridge #(
        .NUM_REGS (NR),
        .REG_BYTES(4),
        .RO_MASK  (16'h0040),
        .RST_VAL  ({512{1'b0}}),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .reg_q      (reg_q),
        .ro_d       (ro_d),
        .wr_stb     (wr_stb),
        .rd_stb     (rd_stb),
        .timeout_err(timeout_err),
        .rx_drop    (rx_drop),
        .busy       (busy)
    );

    // Pulse and handshake monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (|wr_stb) begin wr_pulses += $countones(wr_stb); last_wr = wr_stb; end
        if (|rd_stb) begin rd_pulses += $countones(rd_stb); last_rd = rd_stb; end
        if (timeout_err) tmo_pulses++;
        if (rx_drop) drop_pulses++;
        if (tx_valid && tx_ready) accepts++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slice(input int i);
        return reg_q[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic write_reg(input logic [7:0] cmd, input logic [31:0] val);
        send_byte(cmd);
        for (int k = 0; k < 4; k++) send_byte(val[k*8 +: 8]);
    endtask

    task automatic pop_byte(input string tag, input int stall, input logic [7:0] exp);
        tx_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, " hold"}, {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, exp});
        end
        chk(tag, {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, exp});
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic read_reg(input string tag, input logic [7:0] cmd, input int stall,
                            input logic [31:0] exp);
        send_byte(cmd);
        for (int k = 0; k < 4; k++) pop_byte(tag, stall, exp[k*8 +: 8]);
        chk({tag, " done"}, {30'h0, busy, tx_valid}, 32'h0);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NR; i++) chk(tag, slice(i), model[i]);
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        ro_d     = {512{1'b0}};
        ro_d[6*32 +: 32] = 32'hDEADBEEF;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst tx", {23'h0, tx_valid, tx_data}, 32'h0);
        chk("rst flags", {28'h0, busy, timeout_err, rx_drop, 1'b0}, 32'h0);
        chk("rst stb", {wr_stb, rd_stb}, 32'h0);
        check_all("rst regs");

        // 1: write then read back
        wr_pulses = 0;
        write_reg(8'h83, 32'h12345678);
        model[3] = 32'h12345678;
        chk("wr reg3", slice(3), 32'h12345678);
        chk("wr stb", {16'h0, wr_stb}, 32'h0008);
        tick();
        chk("wr stb clr", {16'h0, wr_stb}, 32'h0);
        chk("wr pulses", wr_pulses, 32'd1);
        rd_pulses = 0;
        read_reg("rd3", 8'h03, 0, 32'h12345678);
        chk("rd pulses", rd_pulses, 32'd1);
        chk("rd stb idx", {16'h0, last_rd}, 32'h0008);

        // 2: backpressure
        accepts = 0;
        read_reg("bp", 8'h03, 20, 32'h12345678);
        chk("bp accepts", accepts, 32'd4);

        // 3: timeout abandons partial write, next byte is a command
        tmo_pulses = 0;
        send_byte(8'h85);
        send_byte(8'hAA);
        repeat (TMO - 1) tick();
        chk("tmo pending", {30'h0, busy, timeout_err}, 32'h2);
        tick();
        chk("tmo fire", {30'h0, busy, timeout_err}, 32'h1);
        tick();
        chk("tmo pulses", tmo_pulses, 32'd1);
        chk("tmo reg5", slice(5), 32'h0);
        read_reg("tmo rd5", 8'h05, 0, 32'h0);
        // byte on the expiry cycle wins
        write_reg(8'h87, 32'h0);
        send_byte(8'h87);
        send_byte(8'h01);
        repeat (TMO - 1) tick();
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        model[7] = 32'h04030201;
        chk("tmo edge reg7", slice(7), 32'h04030201);
        chk("tmo edge pulses", tmo_pulses, 32'd1);

        // 4: read-only and out-of-range
        send_byte(8'h06);
        pop_byte("ro6", 1, 8'hEF);
        ro_d[6*32 +: 32] = 32'h11223344;
        pop_byte("ro6", 1, 8'hBE);
        pop_byte("ro6", 0, 8'hAD);
        pop_byte("ro6", 0, 8'hDE);
        chk("ro6 done", {30'h0, busy, tx_valid}, 32'h0);
        wr_pulses = 0;
        write_reg(8'h86, 32'hCAFEF00D);
        tick();
        chk("ro wr pulses", wr_pulses, 32'd0);
        read_reg("ro6 live", 8'h06, 0, 32'h11223344);
        rd_pulses = 0;
        read_reg("oor rd", 8'h20, 0, 32'h55555555);
        chk("oor rd pulses", rd_pulses, 32'd0);
        write_reg(8'hA0, 32'h89ABCDEF);
        tick();
        chk("oor wr pulses", wr_pulses, 32'd0);
        check_all("oor regs");

        // 5: rx during read is dropped
        drop_pulses = 0;
        send_byte(8'h03);
        send_byte(8'hC1);
        chk("drop pulse", {30'h0, busy, rx_drop}, 32'h3);
        for (int k = 0; k < 4; k++) pop_byte("drop rd", 2, model[3][k*8 +: 8]);
        chk("drop done", {30'h0, busy, tx_valid}, 32'h0);
        chk("drop pulses", drop_pulses, 32'd1);
        check_all("drop regs");

        // 6: async reset mid-write and mid-read
        send_byte(8'h84);
        send_byte(8'h11);
        send_byte(8'h22);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        chk("arst wr", {30'h0, busy, tx_valid}, 32'h0);
        check_all("arst regs");
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h01);
        chk("arst rd pre", {30'h0, busy, tx_valid}, 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("arst rd", {30'h0, busy, tx_valid}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        write_reg(8'h84, 32'hA5A50F0F);
        model[4] = 32'hA5A50F0F;
        check_all("post rst");
        read_reg("post rd4", 8'h04, 1, 32'hA5A50F0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
Generic byte-stream register bridge between the UART subsystem (uart_ss byte interface) and a parametrised bank of multi-byte control/status registers.
It replaces the fixed 1-byte command decoder in the SD SPI top level:
- Registers are REG_BYTES wide with atomic write commit and coherent snapshot reads.
- The tx side has backpressure.
- Abandoned writes are discarded by an inter-byte timeout.
- Any register can be marked read-only; its read data then comes from live status inputs.

Parameters:
NUM_REGS, 16, number of registers; range 1..128 (7-bit address).
REG_BYTES, 4, bytes per register; range 1..4; transferred LSB first.
RO_MASK, {NUM_REGS{1'b0}}, bit i=1: reg i is read-only and reads from ro_d slice i.
RST_VAL, all zeros (NUM_REGS*REG_BYTES*8 bits), reset value of the reg_q storage.
TIMEOUT, 960000, idle clk cycles allowed between bytes of a write (10 ms at 96 MHz); minimum 2.

Ports:
clk  in  1  system clock (clk96m domain)
rst  in  1  asynchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe qualifying rx_data; no ready, cannot be stalled
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  uart accepts the byte when tx_valid&tx_ready
reg_q  out  NUM_REGS*REG_BYTES*8  register storage; reg i at bits [i*W+:W], W=REG_BYTES*8
ro_d  in  NUM_REGS*REG_BYTES*8  live status values for read-only registers
wr_stb  out  NUM_REGS  one-cycle pulse on reg i commit
rd_stb  out  NUM_REGS  one-cycle pulse when a read of reg i is snapshotted (clear-on-read hook)
timeout_err  out  1  one-cycle pulse when a partial write is abandoned
rx_drop  out  1  one-cycle pulse when a byte arrives during RD_SEND and is discarded
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; reg_q=RST_VAL; tx_valid=0; tx_data=8'h00; wr_stb, rd_stb, timeout_err, rx_drop all 0; byte counter=0; timeout counter=0.
- Command byte, accepted in IDLE on rx_valid: bit7=1 write, bit7=0 read; bits[6:0]=address addr.
- IDLE -> WR_DATA (bit7=1): byte_cnt cleared, timeout counter cleared.
- WR_DATA, data bytes: each rx_valid loads shadow byte byte_cnt and clears the timeout counter.
- WR_DATA, final byte (byte_cnt=REG_BYTES-1): state -> IDLE. If addr<NUM_REGS and RO_MASK[addr]=0, then reg_q slice addr takes the shadow value with the final byte in the same edge; new value visible the cycle after the final rx_valid; wr_stb[addr] pulses in that same cycle.
- WR_DATA, discarded writes: out-of-range or read-only address -> bytes consumed, no update, no strobe.
- WR_DATA, timeout: no rx_valid for TIMEOUT consecutive cycles -> timeout_err pulse, shadow discarded, -> IDLE. A byte arriving exactly on the expiry cycle wins (no timeout).
- IDLE -> RD_SEND (bit7=0), one edge: snapshot = ro_d slice if RO_MASK[addr], else reg_q slice if addr<NUM_REGS, else REG_BYTES copies of 8'h55. rd_stb[addr] pulses (only if addr<NUM_REGS). tx_valid=1 and tx_data=snapshot byte 0 the cycle after the command rx_valid.
- RD_SEND: on tx_valid&tx_ready, advance to next byte (new tx_data next cycle, tx_valid stays high). After the REG_BYTES-th accept, tx_valid=0 and state -> IDLE. tx_data stays stable while tx_valid&!tx_ready. Later changes to ro_d/reg_q do not affect bytes in flight.
- RD_SEND, rx traffic: any rx_valid -> rx_drop pulse, byte ignored. No timeout in RD_SEND.
- A command byte arriving in the cycle the bridge returns to IDLE is accepted normally.
- Reset mid-transfer aborts it: partial write lost, tx_valid deasserted immediately.

Decomposition:
- Package uart_reg_pkg: state enum (IDLE, WR_DATA, RD_SEND), CMD_WR_BIT=7, ADDR_W=7, FILL_BYTE=8'h55.
- One natural sub-module, uart_reg_bank: storage, RST_VAL, commit port (addr, data, en), read mux with RO_MASK/ro_d, and wr_stb generation.
- Top: FSM, byte counter, shadow/snapshot registers, timeout counter.

Test Plan:
All cases use NUM_REGS=16 and REG_BYTES=4.
1. Write and read back: send 0x83,0x78,0x56,0x34,0x12 -> reg3=0x12345678 one cycle after the last byte; wr_stb[3] is a single pulse. Then send 0x03 with tx_ready=1 -> tx bytes 78,56,34,12 and rd_stb[3] pulses.
2. Backpressure: read reg3 with tx_ready low for 20 cycles before each byte -> tx_data held constant while stalled; exactly 4 accepts, then busy=0.
3. Timeout: send 0x85,0xAA, then idle TIMEOUT cycles -> timeout_err pulses once and reg5 is unchanged. Next byte 0x05 is decoded as a read command (4 bytes out).
4. Read-only and out-of-range: RO_MASK[6]=1 with ro_d slice 6=0xDEADBEEF; read 0x06 -> EF,BE,AD,DE. Change ro_d mid-send -> output unaffected. Write 0x86+4 bytes -> no wr_stb. Read 0x20 -> 55,55,55,55. Write 0xA0+4 bytes -> reg_q unchanged.
5. rx during read: inject rx_valid while in RD_SEND -> rx_drop pulses; read completes intact.
6. Async reset mid-write (after 2 data bytes) -> reg_q=RST_VAL, tx_valid=0, busy=0 without waiting for a clock edge. A following full write succeeds.
